// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the byte-stream command scheduler: opcodes, FSM states, argument width.
// Optional build macro ARG_TIMEOUT_EN is consumed by cmd_sched.sv, not here.
package cmd_sched_pkg;

  localparam int ARG_W = 24;

  localparam logic [7:0] OP_ROM_READ  = 8'hF1;
  localparam logic [7:0] OP_RAM_READ  = 8'hF2;
  localparam logic [7:0] OP_LFSR_WRITE = 8'hF3;
  localparam logic [7:0] OP_IN        = 8'hF4;
  localparam logic [7:0] OP_OUT       = 8'hF5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_ROM_RD,
    S_RAM_RD,
    S_LFSR_WR,
    S_IN_GEN,
    S_OUT_SINK
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b >= OP_ROM_READ) && (b <= OP_OUT);
  endfunction

  function automatic state_t op_state(input logic [7:0] op);
    case (op)
      OP_ROM_READ:   return S_ROM_RD;
      OP_RAM_READ:   return S_RAM_RD;
      OP_LFSR_WRITE: return S_LFSR_WR;
      OP_IN:         return S_IN_GEN;
      OP_OUT:        return S_OUT_SINK;
      default:       return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rd_prefetch.sv
// One-entry read buffer between a 1-cycle-latency memory and a valid/ready byte stream.
// The single entry is either in flight (read issued last cycle) or held in the register.
module rd_prefetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       more,
  input  logic [7:0] rdata,
  input  logic       ready,
  output logic       rd,
  output logic       valid,
  output logic [7:0] data
);

  logic       rd_pend;
  logic       buf_valid;
  logic [7:0] buf_data;
  logic       occupied;
  logic       consume;

  assign occupied = buf_valid | rd_pend;
  assign consume  = occupied & ready;
  assign rd       = more & ~flush & (~occupied | consume);
  assign valid    = occupied;
  assign data     = buf_valid ? buf_data : rdata;

  // Data still on the memory bus is captured only if the consumer stalled this cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_pend   <= 1'b0;
      buf_valid <= 1'b0;
      buf_data  <= 8'h00;
    end else begin
      rd_pend <= rd;
      if (rd_pend && !consume) begin
        buf_valid <= 1'b1;
        buf_data  <= rdata;
      end else if (consume) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmd_sched.sv
// Byte-stream command scheduler: echoes data into RAM, runs ROM/RAM reads, LFSR load/generate/sink.
// Define ARG_TIMEOUT_EN to abandon a partial argument after TIMEOUT_CYC idle cycles.
module cmd_sched
  import cmd_sched_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        out_data_i,
  input  logic              out_valid_i,
  output logic              out_ready_o,
  output logic [7:0]        in_data_o,
  output logic              in_valid_o,
  input  logic              in_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_sel_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  output logic              lfsr_ld_o,
  output logic [ARG_W-1:0]  lfsr_val_o,
  output logic              lfsr_step_o,
  input  logic [7:0]        lfsr_i,
  output logic              busy_o
);

  state_t            state;
  logic [7:0]        opcode;
  logic [ARG_W-1:0]  arg;
  logic [1:0]        arg_idx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ARG_W:0]    xfer_cnt;
  logic [ARG_W:0]    issue_cnt;
  logic              out_xfer, in_xfer, count_xfer, last;
  logic              rd_state, pf_flush, pf_more, pf_rd, pf_valid;
  logic [7:0]        pf_data;
`ifdef ARG_TIMEOUT_EN
  logic [31:0]       to_cnt;
`endif

  assign rd_state   = (state == S_ROM_RD) || (state == S_RAM_RD);
  assign out_xfer   = out_valid_i && out_ready_o;
  assign in_xfer    = in_valid_o && in_ready_i;
  assign count_xfer = (state == S_OUT_SINK) ? out_xfer : in_xfer;
  assign last       = (xfer_cnt == {1'b0, arg});
  assign pf_flush   = !rd_state;
  assign pf_more    = (issue_cnt <= {1'b0, arg});
  assign busy_o     = (state != S_IDLE);
  assign lfsr_val_o = arg;

  rd_prefetch u_prefetch (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (pf_flush),
    .more  (pf_more),
    .rdata (mem_rdata_i),
    .ready (in_ready_i),
    .rd    (pf_rd),
    .valid (pf_valid),
    .data  (pf_data)
  );

  // Echo path in IDLE is combinational so a data byte moves only when the IN side can take it.
  always_comb begin
    out_ready_o = 1'b0;
    in_valid_o  = 1'b0;
    in_data_o   = 8'h00;
    mem_addr_o  = '0;
    mem_rd_o    = 1'b0;
    mem_sel_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_wdata_o = 8'h00;
    lfsr_ld_o   = 1'b0;
    lfsr_step_o = 1'b0;
    case (state)
      S_IDLE: begin
        out_ready_o = in_ready_i;
        mem_addr_o  = wr_ptr;
        if (out_valid_i && !is_opcode(out_data_i)) begin
          in_valid_o  = 1'b1;
          in_data_o   = out_data_i;
          ram_we_o    = in_ready_i;
          mem_sel_o   = in_ready_i;
          ram_wdata_o = out_data_i;
        end
      end
      S_ARG: out_ready_o = 1'b1;
      S_ROM_RD, S_RAM_RD: begin
        in_valid_o = pf_valid;
        in_data_o  = pf_valid ? pf_data : 8'h00;
        mem_rd_o   = pf_rd;
        mem_sel_o  = (state == S_RAM_RD);
        mem_addr_o = issue_cnt[ADDR_W-1:0];
      end
      S_LFSR_WR: lfsr_ld_o = 1'b1;
      S_IN_GEN: begin
        in_valid_o  = 1'b1;
        in_data_o   = lfsr_i;
        lfsr_step_o = in_ready_i;
      end
      S_OUT_SINK: begin
        out_ready_o = 1'b1;
        lfsr_step_o = out_valid_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      opcode    <= 8'h00;
      arg       <= '0;
      arg_idx   <= 2'd0;
      wr_ptr    <= '0;
      xfer_cnt  <= '0;
      issue_cnt <= '0;
`ifdef ARG_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          xfer_cnt  <= '0;
          issue_cnt <= '0;
          arg_idx   <= 2'd0;
`ifdef ARG_TIMEOUT_EN
          to_cnt    <= '0;
`endif
          if (out_xfer) begin
            if (is_opcode(out_data_i)) begin
              opcode <= out_data_i;
              state  <= S_ARG;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        S_ARG: begin
          // Little-endian: each new byte enters at the top and shifts earlier bytes down.
          if (out_xfer) begin
            arg     <= {out_data_i, arg[ARG_W-1:8]};
            arg_idx <= arg_idx + 1'b1;
            if (arg_idx == 2'd2) state <= op_state(opcode);
          end
`ifdef ARG_TIMEOUT_EN
          if (out_xfer) begin
            to_cnt <= '0;
          end else if (to_cnt == 32'(TIMEOUT_CYC - 1)) begin
            to_cnt <= '0;
            state  <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_LFSR_WR: state <= S_IDLE;
        S_ROM_RD, S_RAM_RD, S_IN_GEN, S_OUT_SINK: begin
          if (pf_rd) issue_cnt <= issue_cnt + 1'b1;
          if (count_xfer) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (last) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Self-checking bench for cmd_sched with ROM/RAM/LFSR models and an IN-stream scoreboard.
// Build with ARG_TIMEOUT_EN defined to exercise the argument timeout path instead of the wait path.
module tb_cmd_sched;

  localparam int ADDR_W = 10;
  localparam int TO_CYC = 40;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [7:0]        out_data_i;
  logic              out_valid_i;
  logic              out_ready_o;
  logic [7:0]        in_data_o;
  logic              in_valid_o;
  logic              in_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_o;
  logic              mem_sel_o;
  logic [7:0]        mem_rdata_i;
  logic              ram_we_o;
  logic [7:0]        ram_wdata_o;
  logic              lfsr_ld_o;
  logic [23:0]       lfsr_val_o;
  logic              lfsr_step_o;
  logic [7:0]        lfsr_i;
  logic              busy_o;

  cmd_sched #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_sel_o(mem_sel_o), .mem_rdata_i(mem_rdata_i),
    .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .lfsr_ld_o(lfsr_ld_o), .lfsr_val_o(lfsr_val_o), .lfsr_step_o(lfsr_step_o), .lfsr_i(lfsr_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int step_cnt = 0;
  int ld_cnt = 0;
  logic [23:0] ld_val = '0;
  logic [7:0] exp_q[$];
  logic [7:0] ram[0:1023];
  logic [23:0] lfsr;
  logic ram_load;
  int exp_wr;

  typedef struct {
    logic [7:0] data;
    logic       rdy;
    logic       exp_ordy;
    logic       exp_ivld;
    logic       exp_we;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [7:0] rom_byte(input int a);
    return 8'(a * 37 + (a >> 8) * 11);
  endfunction

  function automatic logic [7:0] ram_init(input int a);
    return 8'(a * 5 + 3);
  endfunction

  function automatic logic [7:0] dbyte(input int i);
    return 8'(i * 3 + 16);
  endfunction

  function automatic logic [23:0] lfsr_next(input logic [23:0] l);
    return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Memory and LFSR models react to the DUT strobes at the clock edge.
  assign lfsr_i = lfsr[7:0];
  always @(posedge clk_i) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= ram_init(i);
    end else if (ram_we_o) begin
      ram[mem_addr_o] <= ram_wdata_o;
    end
    if (mem_rd_o) mem_rdata_i <= mem_sel_o ? ram[mem_addr_o] : rom_byte(int'(mem_addr_o));
    if (lfsr_ld_o) lfsr <= lfsr_val_o;
    else if (lfsr_step_o) lfsr <= lfsr_next(lfsr);
  end

  // Scoreboard pop: every IN transfer must match the next expected byte.
  always @(negedge clk_i) begin
    if (in_valid_o && in_ready_i) begin
      if (exp_q.size() == 0) check("in_unexpected", {24'h0, in_data_o}, 32'hFFFF_FFFF);
      else check("in_data", {24'h0, in_data_o}, {24'h0, exp_q.pop_front()});
      rx_cnt++;
    end
    if (lfsr_step_o) step_cnt++;
    if (lfsr_ld_o) begin
      ld_cnt++;
      ld_val = lfsr_val_o;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input vec_t v);
    out_data_i  = v.data;
    out_valid_i = 1'b1;
    in_ready_i  = v.rdy;
    if (v.rdy && v.exp_ivld) exp_q.push_back(v.data);
  endtask

  task automatic checkOutput(input vec_t v);
    @(negedge clk_i);
    check("vec_out_ready", out_ready_o, v.exp_ordy);
    check("vec_in_valid", in_valid_o, v.exp_ivld);
    check("vec_ram_we", ram_we_o, v.exp_we);
    check("vec_wr_ptr", mem_addr_o, exp_wr);
    if (v.exp_ivld) check("vec_in_data", in_data_o, v.data);
    @(posedge clk_i); #1;
    if (v.rdy && v.exp_ordy) exp_wr++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    @(negedge clk_i);
    while (!out_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!out_ready_o) check("send_timeout", 0, 1);
    @(posedge clk_i); #1;
    out_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [23:0] a);
    in_ready_i = 1'b1;
    send_byte(op);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(a[23:16]);
  endtask

  task automatic wait_idle(input int max, input bit toggle);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < max) begin
      @(posedge clk_i); #1;
      if (toggle) in_ready_i = !in_ready_i;
      @(negedge clk_i);
      n++;
    end
    check("wait_idle", busy_o, 0);
    @(posedge clk_i); #1;
    in_ready_i = 1'b1;
  endtask

  initial begin
    logic [23:0] l;
    logic [7:0] sink[10];
    int rx0;
    bit got;

    vecs[0] = '{8'hF3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 1; k <= 7; k++) vecs[k+1] = '{8'(k), 1'b1, 1'b1, 1'b1, 1'b1};
    sink = '{8'h00, 8'hF1, 8'hF5, 8'h41, 8'hFF, 8'h10, 8'hF2, 8'h7E, 8'hF4, 8'h99};

    rst_i = 1'b1; out_valid_i = 1'b0; out_data_i = 8'h00; in_ready_i = 1'b0; ram_load = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 ram_load = 1'b0;
    @(negedge clk_i);
    check("rst_ctrl", {busy_o, in_valid_o, out_ready_o, mem_rd_o, ram_we_o, lfsr_ld_o, lfsr_step_o, mem_sel_o}, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_buses", {in_data_o, ram_wdata_o}, 0);
    check("rst_lfsr_val", lfsr_val_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    exp_wr = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    @(negedge clk_i);
    check("echo_wr_ptr", mem_addr_o, 7);
    check("echo_all_seen", exp_q.size(), 0);
    for (int i = 0; i < 7; i++) check("echo_ram", ram[i], i + 1);
    @(posedge clk_i); #1;

    for (int a = 0; a < 1024; a++) exp_q.push_back(rom_byte(a));
    send_cmd(8'hF1, 24'h0003FF);
    wait_idle(5000, 1);
    @(negedge clk_i);
    check("rom_all_popped", exp_q.size(), 0);
    check("rom_wr_ptr_kept", mem_addr_o, 7);
    @(posedge clk_i); #1;

    for (int a = 0; a < 16; a++) exp_q.push_back(rom_byte(a));
    send_cmd(8'hF1, 24'h00000F);
    rx0 = rx_cnt;
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk_i); #1;
      if (rx_cnt - rx0 >= 4) got = 1;
    end
    check("rst_mid_reach", got, 1);
    rst_i = 1'b1; in_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; in_ready_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check("rst_mid_in_valid", in_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    repeat (20) @(posedge clk_i);
    #1;
    check("rst_mid_rx", rx_cnt - rx0, 4);

    for (int i = 0; i < 55; i++) begin
      exp_q.push_back(dbyte(i));
      send_byte(dbyte(i));
    end
    for (int i = 0; i < 55; i++) exp_q.push_back(dbyte(i));
    send_cmd(8'hF2, 24'h000036);
    wait_idle(500, 0);
    @(negedge clk_i);
    check("ram55_popped", exp_q.size(), 0);
    check("ram55_wr_ptr", mem_addr_o, 55);
    @(posedge clk_i); #1;
    for (int i = 0; i < 1024; i++) exp_q.push_back(i < 55 ? dbyte(i) : ram_init(i));
    exp_q.push_back(dbyte(0));
    send_cmd(8'hF2, 24'h000400);
    wait_idle(4000, 1);
    @(negedge clk_i);
    check("ramwrap_popped", exp_q.size(), 0);
    check("ramwrap_wr_ptr", mem_addr_o, 55);
    @(posedge clk_i); #1;

    ld_cnt = 0;
    send_cmd(8'hF3, 24'h333881);
    wait_idle(20, 0);
    check("lfsr_ld_pulses", ld_cnt, 1);
    check("lfsr_ld_val", ld_val, 24'h333881);
    l = 24'h333881;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(l[7:0]);
      l = lfsr_next(l);
    end
    step_cnt = 0;
    send_cmd(8'hF4, 24'h000009);
    wait_idle(100, 1);
    check("ingen_steps", step_cnt, 10);
    check("ingen_popped", exp_q.size(), 0);

    step_cnt = 0;
    send_cmd(8'hF5, 24'h000009);
    for (int k = 0; k < 10; k++) send_byte(sink[k]);
    @(negedge clk_i);
    check("sink_idle_after", busy_o, 0);
    check("sink_steps", step_cnt, 10);
    @(posedge clk_i); #1;
    exp_q.push_back(8'h41);
    send_byte(8'h41);
    @(negedge clk_i);
    check("sink_echo_after", exp_q.size(), 0);
    check("sink_wr_ptr", mem_addr_o, 56);
    @(posedge clk_i); #1;

`ifdef ARG_TIMEOUT_EN
    send_byte(8'hF1);
    send_byte(8'h00);
    repeat (30) @(posedge clk_i);
    @(negedge clk_i);
    check("to_still_busy", busy_o, 1);
    repeat (15) @(posedge clk_i);
    @(negedge clk_i);
    check("to_returned_idle", busy_o, 0);
    @(posedge clk_i); #1;
    exp_q.push_back(8'h41);
    send_byte(8'h41);
    @(negedge clk_i);
    check("to_echo", exp_q.size(), 0);
    @(posedge clk_i); #1;
`else
    send_byte(8'hF1);
    send_byte(8'h00);
    repeat (100) @(posedge clk_i);
    @(negedge clk_i);
    check("noto_waiting", busy_o, 1);
    @(posedge clk_i); #1;
    exp_q.push_back(rom_byte(0));
    send_byte(8'h00);
    send_byte(8'h00);
    wait_idle(50, 0);
    check("noto_popped", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
